// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the I-fetch and D-stage ports.
// Optional round-robin tie-break is enabled with `define ARB_RR_EN.
module mem_port_arbiter #(
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic [15:0] i_rdata,
   output logic        i_done,
   output logic        i_stall,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_rdata,
   output logic        d_done,
   output logic        d_stall,
   input  logic        createdump,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   input  logic [15:0] mem_data_out,
   output logic        mem_createdump
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;   // 1 = D owns the memory
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] i_rdata_q, i_rdata_d;
   logic [15:0] d_rdata_q, d_rdata_d;
   logic        grant_d;            // 1 = D wins the IDLE sample

`ifdef ARB_RR_EN
   logic last_q, last_d;

   // On a tie the port that did not own the previous transaction wins.
   always_comb begin
      last_d  = last_q;
      grant_d = (i_req && d_req) ? ~last_q : d_req;
      if (state_q == IDLE && (i_req || d_req)) last_d = grant_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) last_q <= 1'b0;
      else      last_q <= last_d;
   end
`else
   assign grant_d = d_req;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               owner_d = grant_d;
               addr_d  = grant_d ? d_addr : i_addr;
               wr_d    = grant_d & d_wr;
               wdata_d = grant_d ? d_wdata : 16'h0000;
               cnt_d   = 4'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = RESP;
               if (owner_q) d_rdata_d = wr_q ? 16'h0000 : mem_data_out;
               else         i_rdata_d = mem_data_out;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         owner_q   <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= 16'h0000;
         wdata_q   <= 16'h0000;
         i_rdata_q <= 16'h0000;
         d_rdata_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // Write strobe only on the final BUSY cycle so each write lands once.
   assign mem_enable     = (state_q == BUSY);
   assign mem_wr         = mem_enable & wr_q & (cnt_q == 4'd0);
   assign mem_addr       = addr_q;
   assign mem_data_in    = wdata_q;
   assign mem_createdump = createdump;

   assign i_done  = (state_q == RESP) & ~owner_q;
   assign d_done  = (state_q == RESP) &  owner_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign i_stall = i_req & ~i_done;
   assign d_stall = d_req & ~d_done;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory2c-style memory between the instruction-fetch port (I) and the data/memory-stage port (D) of the processor.
- Accepts requests from both ports, selects one, and drives the memory for LATENCY cycles.
- Captures the read data and returns a one-cycle done pulse to the winning port.
- Drives stall signals so the pipeline holds the losing or waiting stage.

Parameters:
- LATENCY, 2, memory-access cycles per transaction (legal 1..15).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- i_req  in  1  instruction read request; held with i_addr until i_done.
- i_addr  in  16  instruction address.
- i_rdata  out  16  instruction read data; valid only while i_done=1.
- i_done  out  1  one-cycle completion pulse for I.
- i_stall  out  1  equals i_req & ~i_done.
- d_req  in  1  data request; held with d_wr, d_addr, d_wdata until d_done.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  16  data address.
- d_wdata  in  16  write data.
- d_rdata  out  16  data read data; valid only while d_done=1; 0 for writes.
- d_done  out  1  one-cycle completion pulse for D.
- d_stall  out  1  equals d_req & ~d_done.
- createdump  in  1  dump request; passed straight to mem_createdump.
- mem_enable  out  1  memory enable.
- mem_wr  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_data_in  out  16  memory write data.
- mem_data_out  in  16  memory read data; combinational from mem_addr.
- mem_createdump  out  1  equals createdump.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE, the counter clears, the owner clears, and rdata registers clear to 0.
  - Outputs i_done, d_done, mem_enable and mem_wr go to 0 immediately; mem_addr and mem_data_in go to 0.
  - A reset asserted mid-transaction aborts it. No write occurs and no done pulse is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - mem_enable=0.
  - On a rising edge with any request high: latch the winner's addr/wr/wdata and the owner, set cnt=LATENCY-1, and go to BUSY.
  - Fixed priority: D wins over I.
- BUSY:
  - mem_enable=1; mem_addr and mem_data_in come from the latched values.
  - mem_wr = latched_wr & (cnt==0), so a write is performed exactly once, on the last BUSY edge.
  - When cnt≠0, each edge decrements cnt.
  - When cnt==0, the edge captures mem_data_out into the owner's rdata register (reads only) and the FSM goes to RESP.
- RESP:
  - The owner's done=1 for exactly one cycle; mem_enable=0.
  - The FSM always returns to IDLE on the next edge.
  - The requester must drop req in the cycle after done.
  - Request-to-done latency: LATENCY+1 cycles after the sampling edge. Minimum spacing between grants: LATENCY+2 cycles.
- Request signals that change while BUSY are ignored; latched values are used.
- Both requests high in IDLE: D is served first. I stays stalled and is granted at the next IDLE sample.
- i_done and d_done are never high in the same cycle.
- The non-owner's rdata register holds its previous value; it is only defined while that port's done=1.
- I port never writes: mem_wr=0 whenever owner=I.
- createdump is purely combinational and unaffected by state or reset.

Optional Feature:
- ARB_RR_EN defined: round-robin tie-break.
  - A 1-bit last_owner register resets to I, so D wins the first tie.
  - On a tie, the port that did not own the previous transaction wins.
  - A lone requester always wins.
- ARB_RR_EN undefined: fixed D-over-I priority. No last_owner register is built.

Test Plan:
- Single D write: d_req=1, d_wr=1, d_addr=16'h0004, d_wdata=16'hFFFF.
  - Required: mem_wr=1 for exactly one cycle (the 2nd BUSY cycle, LATENCY=2).
  - Required: d_done pulses 3 cycles after the sampling edge.
  - A following D read of 16'h0004 returns d_rdata=16'hFFFF.
- I read: memory preloaded with 16'h0000=16'hABCD; i_req=1, i_addr=16'h0000.
  - Required: i_stall=1 until i_done; i_rdata=16'hABCD while i_done=1; mem_wr stays 0 throughout.
- Simultaneous requests: i_req=1 (addr 16'h0002) and d_req=1 (read 16'h0000) in the same cycle.
  - Without ARB_RR_EN: d_done comes first, then i_done 4 cycles later.
  - With ARB_RR_EN and both held continuously: D, I, D, I grant order.
- Reset mid-write: assert rst=0 during the first BUSY cycle of a D write to 16'h0006=16'h5555.
  - Required: all done and mem outputs go to 0 immediately.
  - Required: a subsequent read of 16'h0006 returns the original value, not 16'h5555.
- Dump passthrough: toggle createdump in IDLE, BUSY and during reset.
  - Required: mem_createdump follows createdump in the same cycle every time.
- LATENCY=1 build: a D read of 16'h0002=16'h1234 gives d_done 2 cycles after the sampling edge with d_rdata=16'h1234.
